// File: rtl/div_const_pipe.sv
// div_const_pipe: pipelined unsigned divide by a constant, one radix-2^RADIX_BITS digit per stage.
// Optional remainder output R is built when DIVC_REM_EN is defined.
module div_const_pipe #(
    parameter int WIDTH      = 16,
    parameter int DIVISOR    = 23,
    parameter int RADIX_BITS = 4,
    localparam int STAGES    = (WIDTH + RADIX_BITS - 1) / RADIX_BITS,
    localparam int RW        = $clog2(DIVISOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q
`ifdef DIVC_REM_EN
    ,
    output logic [RW-1:0]    R
`endif
);
    localparam int RB = RADIX_BITS;
    localparam int PW = STAGES * RB;
    localparam int LW = RB + RW;
    localparam int N  = DIVISOR * (1 << RB);
    localparam int TW = RW + RB;
`ifdef DIVC_REM_EN
    localparam int RS = STAGES;
`else
    localparam int RS = STAGES - 1;
`endif

    // entry t = {t / DIVISOR, t % DIVISOR} for t = rem_prev*2^RB + digit
    function automatic logic [N*LW-1:0] build_lut();
        logic [N*LW-1:0] l;
        l = '0;
        for (int t = 0; t < N; t++)
            l[t*LW +: LW] = {RB'(t / DIVISOR), RW'(t % DIVISOR)};
        return l;
    endfunction

    localparam logic [N*LW-1:0] LUT = build_lut();

    logic [STAGES-1:0] vld, v_src, rdy;
    logic [PW-1:0]     x_r [STAGES];
    logic [PW-1:0]     q_r [STAGES];
    logic [RW-1:0]     rem_r [STAGES];
    logic [PW-1:0]     x_src [STAGES];
    logic [PW-1:0]     q_src [STAGES];
    logic [RW-1:0]     rem_src [STAGES];
    logic [TW-1:0]     idx [STAGES];
    logic [LW-1:0]     ent [STAGES];

    always_comb begin
        v_src[0]   = in_valid;
        x_src[0]   = PW'(X);
        q_src[0]   = '0;
        rem_src[0] = '0;
        for (int s = 1; s < STAGES; s++) begin
            v_src[s]   = vld[s-1];
            x_src[s]   = x_r[s-1];
            q_src[s]   = q_r[s-1];
            rem_src[s] = rem_r[s-1];
        end
        // stage s is ready unless it and every stage after it are full and the output is stalled
        for (int s = 0; s < STAGES; s++) begin
            rdy[s] = out_ready || !(&(vld | STAGES'((1 << s) - 1)));
            idx[s] = {rem_src[s], x_src[s][PW-1 -: RB]};
            ent[s] = LUT[int'(idx[s])*LW +: LW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int s = 0; s < STAGES; s++) begin
                x_r[s] <= '0;
                q_r[s] <= '0;
                if (s < RS) rem_r[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (rdy[s]) begin
                    vld[s] <= v_src[s];
                    if (v_src[s]) begin
                        x_r[s] <= x_src[s] << RB;
                        q_r[s] <= (q_src[s] << RB) | PW'(ent[s][LW-1 -: RB]);
                        if (s < RS) rem_r[s] <= ent[s][RW-1:0];
                    end
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld[STAGES-1];
    assign Q         = q_r[STAGES-1][WIDTH-1:0];
`ifdef DIVC_REM_EN
    assign R         = rem_r[STAGES-1];
`endif
endmodule

// File: tb/tb_div_const_pipe.sv
// tb_div_const_pipe: directed checks of div_const_pipe at WIDTH=16, DIVISOR=23, RADIX_BITS=4.
module tb_div_const_pipe;
    localparam int RW = 5;
    logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
    logic [15:0] x = 0;
    logic in_ready, out_valid;
    logic [15:0] q;
    logic [RW-1:0] r;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    div_const_pipe #(.WIDTH(16), .DIVISOR(23), .RADIX_BITS(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .X(x),
        .out_valid(out_valid), .out_ready(out_ready), .Q(q)
`ifdef DIVC_REM_EN
        , .R(r)
`endif
    );
`ifndef DIVC_REM_EN
    assign r = '0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_r(input string tag, input logic [31:0] exp);
`ifdef DIVC_REM_EN
        chk(tag, 32'(r), exp);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] xs [6] = '{16'd100, 16'd200, 16'd300, 16'd400, 16'd500, 16'd600};
    logic [15:0] qs [6] = '{16'd4, 16'd8, 16'd13, 16'd17, 16'd21, 16'd26};
    logic [4:0]  rs [6] = '{5'd8, 5'd16, 5'd1, 5'd9, 5'd17, 5'd2};
    logic [15:0] bx [4] = '{16'd0, 16'd22, 16'd23, 16'd46};
    logic [15:0] bq [4] = '{16'd0, 16'd0, 16'd1, 16'd2};
    logic [4:0]  br [4] = '{5'd0, 5'd22, 5'd0, 5'd0};
    logic [15:0] sb [$];

    initial begin
        int k, n, stale;
        logic acc;
        logic [15:0] e;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_q", 32'(q), 0);
        chk_r("rst_r", 0);
        @(negedge clk);
        rst = 0;
        tick();
        chk("rst_in_ready", 32'(in_ready), 1);

        // single max operand, latency 4
        x = 16'hFFFF;
        in_valid = 1;
        tick();
        in_valid = 0;
        tick();
        tick();
        chk("lat_early", 32'(out_valid), 0);
        tick();
        chk("lat_valid", 32'(out_valid), 1);
        chk("max_q", 32'(q), 2849);
        chk_r("max_r", 8);
        tick();
        chk("lat_one_cycle", 32'(out_valid), 0);

        // back-to-back boundary operands
        for (int i = 0; i < 7; i++) begin
            in_valid = (i < 4);
            x = bx[i % 4];
            #1;
            if (i < 4) chk("b2b_in_ready", 32'(in_ready), 1);
            tick();
            if (i >= 3) begin
                chk("b2b_valid", 32'(out_valid), 1);
                chk("b2b_q", 32'(q), 32'(bq[i-3]));
                chk_r("b2b_r", 32'(br[i-3]));
            end
        end
        in_valid = 0;
        tick();
        chk("b2b_drained", 32'(out_valid), 0);

        // fill under stall
        out_ready = 0;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = (k < 6);
            x = xs[k % 6];
            #1;
            acc = in_valid && in_ready;
            tick();
            if (acc) k++;
        end
        chk("full_accepts", 32'(k), 4);
        #1;
        chk("full_in_ready", 32'(in_ready), 0);
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_q", 32'(q), 4);
        chk_r("stall_r", 8);
        tick();
        tick();
        chk("stall_hold_q", 32'(q), 4);
        out_ready = 1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = (k < 6);
            x = xs[k % 6];
            #1;
            acc = in_valid && in_ready;
            if (out_valid) begin
                chk("drain_q", 32'(q), 32'(qs[n % 6]));
                chk_r("drain_r", 32'(rs[n % 6]));
                n++;
            end
            tick();
            if (acc) k++;
        end
        chk("drain_count", 32'(n), 6);

        // gap collapse
        in_valid = 0;
        out_ready = 0;
        x = 16'd100;
        in_valid = 1;
        tick();
        in_valid = 0;
        tick();
        tick();
        x = 16'd1000;
        in_valid = 1;
        tick();
        in_valid = 0;
        for (int i = 0; i < 6; i++) tick();
        chk("gap_q0", 32'(q), 4);
        chk_r("gap_r0", 8);
        out_ready = 1;
        tick();
        chk("gap_adjacent", 32'(out_valid), 1);
        chk("gap_q1", 32'(q), 43);
        chk_r("gap_r1", 11);
        tick();
        chk("gap_empty", 32'(out_valid), 0);

        // reset with ops in flight
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            x = 16'(46 + 23 * i);
            in_valid = 1;
            tick();
        end
        in_valid = 0;
        tick();
        tick();
        chk("pre_rst_q", 32'(q), 2);
        rst = 1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_q", 32'(q), 0);
        tick();
        rst = 0;
        out_ready = 1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) stale++;
        end
        chk("no_stale", 32'(stale), 0);

        // random traffic against X/23, X%23
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 1) == 1);
            x = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && in_ready) sb.push_back(x);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("rnd_spurious", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("rnd_q", 32'(q), 32'(e / 16'd23));
                    chk_r("rnd_r", 32'(e % 16'd23));
                end
            end
            tick();
        end
        in_valid = 0;
        out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (out_valid) begin
                if (sb.size() == 0) chk("rnd_spurious", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("rnd_q", 32'(q), 32'(e / 16'd23));
                    chk_r("rnd_r", 32'(e % 16'd23));
                end
            end
            tick();
        end
        chk("rnd_all_out", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
